// File: rtl/tpu_job_scheduler.sv
// Round-robin job queue in front of the systolic controller: launches one job at a time,
// reports each completion once, and recovers a hung run through a watchdog reset pulse.
module tpu_job_scheduler #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TAG_W       = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     srstn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     tpu_start,
  input  logic                     tpu_done,
  output logic                     tpu_srstn,
  output logic                     done_valid,
  output logic [TAG_W-1:0]         done_tag,
  output logic [SRC_W-1:0]         done_src,
  output logic                     done_timeout,
  output logic                     busy,
  output logic [CNT_W-1:0]         queue_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned RUN_W = $clog2(TIMEOUT_CYC);
  localparam logic [RUN_W-1:0] RunLast = RUN_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StRun, StAbort, StReport} state_e;

  state_e                 state_q, state_d;
  logic [SRC_W-1:0]       rr_q, rr_d;
  logic [SRC_W-1:0]       grant_idx, cand;
  logic                   grant_vld;
  logic [SRC_W-1:0]       run_src_q, run_src_d;
  logic [TAG_W-1:0]       run_tag_q, run_tag_d;
  logic [RUN_W-1:0]       run_cnt_q, run_cnt_d;
  logic                   abort_cnt_q, abort_cnt_d;
  logic                   timeout_q, timeout_d;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [SRC_W+TAG_W-1:0] mem_q [DEPTH];
  logic                   push, pop;

  // Registered count gates the grant, so a same-cycle pop never opens a slot.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    req_ready = '0;
    if (count_q < CNT_W'(DEPTH)) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        cand = SRC_W'((32'(rr_q) + off) % NUM_REQ);
        if (!grant_vld && req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_vld) req_ready[grant_idx] = 1'b1;
  end

  assign push = grant_vld;
  assign pop  = (state_q == StLaunch);
  assign rr_d = grant_vld ? SRC_W'((32'(grant_idx) + 1) % NUM_REQ) : rr_q;

  always_comb begin
    state_d     = state_q;
    run_src_d   = run_src_q;
    run_tag_d   = run_tag_q;
    run_cnt_d   = run_cnt_q;
    abort_cnt_d = abort_cnt_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      StIdle: if (count_q != '0) state_d = StLaunch;
      StLaunch: begin
        {run_src_d, run_tag_d} = mem_q[rd_ptr_q];
        run_cnt_d = '0;
        timeout_d = 1'b0;
        state_d   = StRun;
      end
      StRun: begin
        run_cnt_d = run_cnt_q + RUN_W'(1);
        // Completion on the limit cycle takes priority over the watchdog.
        if (tpu_done) begin
          state_d = StReport;
        end else if (run_cnt_q == RunLast) begin
          state_d     = StAbort;
          abort_cnt_d = 1'b0;
          timeout_d   = 1'b1;
        end
      end
      StAbort: begin
        abort_cnt_d = 1'b1;
        if (abort_cnt_q) state_d = StReport;
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      run_src_q   <= '0;
      run_tag_q   <= '0;
      run_cnt_q   <= '0;
      abort_cnt_q <= 1'b0;
      timeout_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      run_src_q   <= run_src_d;
      run_tag_q   <= run_tag_d;
      run_cnt_q   <= run_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      timeout_q   <= timeout_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {grant_idx, req_tag[grant_idx*TAG_W +: TAG_W]};
  end

  assign tpu_start    = (state_q == StLaunch);
  assign tpu_srstn    = srstn & (state_q != StAbort);
  assign done_valid   = (state_q == StReport);
  assign done_tag     = done_valid ? run_tag_q : '0;
  assign done_src     = done_valid ? run_src_q : '0;
  assign done_timeout = done_valid & timeout_q;
  assign busy         = (state_q != StIdle) || (count_q != '0);
  assign queue_count  = count_q;

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Bench for tpu_job_scheduler: arbitration/queue model with a completion scoreboard,
// a table of grant vectors, and directed sequences for latency, watchdog and reset.
module tb_tpu_job_scheduler;

  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 128;

  logic        clk = 1'b0;
  logic        srstn = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_tag = '0;
  logic [1:0]  req_ready;
  logic        tpu_start;
  logic        tpu_done = 1'b0;
  logic        tpu_srstn;
  logic        done_valid;
  logic [7:0]  done_tag;
  logic [0:0]  done_src;
  logic        done_timeout;
  logic        busy;
  logic [2:0]  queue_count;

  tpu_job_scheduler #(
    .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk(clk), .srstn(srstn), .req_valid(req_valid), .req_tag(req_tag),
    .req_ready(req_ready), .tpu_start(tpu_start), .tpu_done(tpu_done),
    .tpu_srstn(tpu_srstn), .done_valid(done_valid), .done_tag(done_tag),
    .done_src(done_src), .done_timeout(done_timeout), .busy(busy),
    .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic src; logic [7:0] tag;} job_t;
  typedef struct {logic [1:0] valid; logic [7:0] tag0; logic [7:0] tag1; logic [1:0] exp_ready;} vec_t;

  job_t       sb[$];
  logic [7:0] done_log[$];
  int checks = 0, failures = 0;
  int cyc = 0;
  int m_rr = 0, m_count = 0;
  int n_starts = 0, n_done = 0, n_aborts = 0;
  int last_start_cyc = 0, last_done_cyc = 0;
  int abort_len = 0, last_abort_len = 0, abort_first_cyc = 0;
  int max_count = 0;
  int done_delay = -1;
  bit exp_timeout = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic bound_fail(input string name, input int got, input int want);
    checks++;
    failures++;
    $display("FAIL %s: timed out with %0d events, expected %0d", name, got, want);
  endtask

  // Reference model of arbitration and queue occupancy; completions checked in FIFO order.
  initial begin
    logic [1:0] er;
    int g;
    job_t e;
    forever begin
      @(negedge clk);
      if (!srstn) begin
        m_rr = 0; m_count = 0; abort_len = 0;
        sb.delete();
      end else begin
        er = '0;
        g = -1;
        if (m_count < DEPTH)
          for (int k = 0; k < NUM_REQ; k++)
            if (g < 0 && req_valid[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("queue_count", 32'(queue_count), m_count);
        if (32'(queue_count) > max_count) max_count = 32'(queue_count);
        if (g >= 0) begin
          sb.push_back(job_t'({g[0], req_tag[g*8 +: 8]}));
          m_rr = (g + 1) % NUM_REQ;
          m_count++;
        end
        if (tpu_start) begin
          n_starts++;
          last_start_cyc = cyc;
          m_count--;
        end
        if (!tpu_srstn) begin
          if (abort_len == 0) abort_first_cyc = cyc;
          abort_len++;
        end else if (abort_len > 0) begin
          last_abort_len = abort_len;
          n_aborts++;
          abort_len = 0;
        end
        if (done_valid) begin
          n_done++;
          last_done_cyc = cyc;
          done_log.push_back(done_tag);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected: got tag 0x%0h expected no completion", done_tag);
          end else begin
            e = sb.pop_front();
            chk("done_tag", 32'(done_tag), 32'(e.tag));
            chk("done_src", 32'(done_src), 32'(e.src));
            chk("done_timeout", 32'(done_timeout), 32'(exp_timeout));
          end
        end
      end
    end
  end

  // Systolic controller stand-in: pulses tpu_done done_delay cycles after tpu_start.
  initial begin
    int pend;
    bit st;
    pend = 0;
    forever begin
      @(negedge clk);
      st = tpu_start & srstn;
      @(posedge clk);
      #1;
      tpu_done = 1'b0;
      if (!srstn) begin
        pend = 0;
      end else begin
        if (st) pend = done_delay;
        if (pend > 0) begin
          pend--;
          if (pend == 0) tpu_done = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    srstn = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    srstn = 1'b1;
  endtask

  task automatic send(input int r, input logic [7:0] tag, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = 0;
    @(posedge clk); #1;
    req_valid[r] = 1'b1;
    req_tag[r*8 +: 8] = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        ok = 1'b1;
        acc_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    if (!ok) bound_fail("send_accept", 0, 1);
  endtask

  task automatic wait_starts(input int target, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (n_starts >= target) return;
    end
    bound_fail(name, n_starts, target);
  endtask

  task automatic wait_done(input int target, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (n_done >= target) return;
    end
    bound_fail(name, n_done, target);
  endtask

  initial begin
    vec_t tv[6];
    logic [7:0] exp_log[5];
    int acc, s0, n0, a0, s1;

    tv[0] = '{2'b11, 8'h01, 8'h11, 2'b01};
    tv[1] = '{2'b11, 8'h02, 8'h11, 2'b10};
    tv[2] = '{2'b11, 8'h02, 8'h12, 2'b01};
    tv[3] = '{2'b11, 8'h02, 8'h12, 2'b10};
    tv[4] = '{2'b10, 8'h02, 8'h13, 2'b10};
    tv[5] = '{2'b00, 8'h02, 8'h13, 2'b00};
    exp_log = '{8'h01, 8'h11, 8'h02, 8'h12, 8'h13};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tpu_srstn", 32'(tpu_srstn), 0);
    chk("rst_tpu_start", 32'(tpu_start), 0);
    chk("rst_done_valid", 32'(done_valid), 0);
    chk("rst_done_tag", 32'(done_tag), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_queue_count", 32'(queue_count), 0);
    @(posedge clk); #1;
    srstn = 1'b1;
    @(negedge clk);
    chk("rst_tpu_srstn_release", 32'(tpu_srstn), 1);

    // 1: single job latency
    done_delay = 85; exp_timeout = 1'b0;
    s0 = n_starts; n0 = n_done;
    send(0, 8'h3A, acc);
    wait_done(n0 + 1, 300, "t1_done");
    chk("t1_start_latency", last_start_cyc - acc, 2);
    chk("t1_start_count", n_starts - s0, 1);
    chk("t1_done_latency", last_done_cyc - last_start_cyc, 86);
    @(negedge clk);
    chk("t1_busy_falls", 32'(busy), 0);

    // 2: round-robin grant table
    do_reset();
    done_delay = 3; exp_timeout = 1'b0;
    done_log.delete();
    n0 = n_done;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_valid = tv[i].valid;
      req_tag = {tv[i].tag1, tv[i].tag0};
      @(negedge clk);
      chk($sformatf("t2_ready_row%0d", i), 32'(req_ready), 32'(tv[i].exp_ready));
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_done(n0 + 5, 200, "t2_done");
    chk("t2_done_count", done_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < done_log.size())
        chk($sformatf("t2_done_order%0d", i), 32'(done_log[i]), 32'(exp_log[i]));

    // 3: fill the queue under continuous requests
    do_reset();
    done_delay = 10; exp_timeout = 1'b0;
    max_count = 0;
    n0 = n_done;
    acc = 0;
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_tag[7:0] = 8'h30;
    for (int i = 0; i < 200 && acc < 8; i++) begin
      @(negedge clk);
      if (req_ready[0]) acc++;
      @(posedge clk); #1;
      req_tag[7:0] = 8'h30 + acc[7:0];
    end
    req_valid = '0;
    chk("t3_accepts", acc, 8);
    wait_done(n0 + 8, 400, "t3_drain");
    chk("t3_max_count", max_count, DEPTH);
    chk("t3_sb_empty", sb.size(), 0);

    // 4: watchdog abort, then the next queued job launches
    do_reset();
    done_delay = -1; exp_timeout = 1'b1;
    s0 = n_starts; n0 = n_done; a0 = n_aborts;
    send(0, 8'h40, acc);
    send(0, 8'h41, acc);
    wait_starts(s0 + 1, 20, "t4_start1");
    s1 = last_start_cyc;
    wait_done(n0 + 1, TIMEOUT + 50, "t4_done1");
    chk("t4_abort_start", abort_first_cyc - s1, TIMEOUT + 1);
    chk("t4_abort_len", last_abort_len, 2);
    chk("t4_done_latency", last_done_cyc - s1, TIMEOUT + 3);
    wait_starts(s0 + 2, 20, "t4_start2");
    chk("t4_next_launch", last_start_cyc - last_done_cyc, 2);
    wait_done(n0 + 2, TIMEOUT + 50, "t4_done2");
    chk("t4_abort_count", n_aborts - a0, 2);

    // 5: completion on the final RUN cycle beats the watchdog
    do_reset();
    done_delay = TIMEOUT; exp_timeout = 1'b0;
    n0 = n_done; a0 = n_aborts;
    send(1, 8'h55, acc);
    wait_done(n0 + 1, TIMEOUT + 50, "t5_done");
    chk("t5_done_latency", last_done_cyc - last_start_cyc, TIMEOUT + 1);
    chk("t5_no_abort", n_aborts - a0, 0);

    // 6: reset mid-RUN with three jobs queued
    do_reset();
    done_delay = -1; exp_timeout = 1'b0;
    send(0, 8'h61, acc);
    send(0, 8'h62, acc);
    send(0, 8'h63, acc);
    send(0, 8'h64, acc);
    @(negedge clk);
    chk("t6_count_before", 32'(queue_count), 3);
    @(posedge clk); #1;
    srstn = 1'b0;
    @(negedge clk);
    chk("t6_tpu_srstn_low", 32'(tpu_srstn), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t6_queue_count", 32'(queue_count), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done_valid", 32'(done_valid), 0);
    chk("t6_tpu_start", 32'(tpu_start), 0);
    chk("t6_tpu_srstn_hold", 32'(tpu_srstn), 0);
    @(posedge clk); #1;
    srstn = 1'b1;
    s0 = n_starts; n0 = n_done;
    repeat (20) @(posedge clk);
    chk("t6_no_start", n_starts - s0, 0);
    chk("t6_no_done", n_done - n0, 0);
    @(negedge clk);
    chk("t6_tpu_srstn_high", 32'(tpu_srstn), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "global timeout");
  end

endmodule
